// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FUNCT3 encodings, FSM states, access
// descriptor and byte/half lane-select helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef struct packed {
    size_e size;
    logic  uns;
  } acc_t;

  // Anything not a legal encoding for the direction collapses to a word access.
  function automatic acc_t decode_funct3(input logic [2:0] f3, input logic we);
    acc_t a;
    a.size = SZ_W;
    a.uns  = 1'b0;
    case (f3)
      F3_B:  a.size = SZ_B;
      F3_H:  a.size = SZ_H;
      F3_BU: if (!we) begin a.size = SZ_B; a.uns = 1'b1; end
      F3_HU: if (!we) begin a.size = SZ_H; a.uns = 1'b1; end
      default: a.size = SZ_W;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] off);
    return w[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] half_lane(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic misaligned(input acc_t a, input logic [1:0] off);
    return ((a.size == SZ_H) && off[0]) || ((a.size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the word-only DATA_MEM port.
// master = pipeline + memory side, slave = load_store_unit.
interface load_store_unit_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_RDATA;
  logic        RESP_FAULT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RESP_READY, MEM_RD,
    input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_FAULT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WD
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RESP_READY, MEM_RD,
    output REQ_READY, RESP_VALID, RESP_RDATA, RESP_FAULT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WD
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: sign/zero-extension of load data and byte/half
// merge of store data into a previously read word.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  acc_t        acc,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = byte_lane(word, offset);
  assign half_s = half_lane(word, offset[1]);

  always_comb begin
    load_data = word;
    case (acc.size)
      SZ_B:    load_data = acc.uns ? {24'h0, byte_s} : 32'(byte_s);
      SZ_H:    load_data = acc.uns ? {16'h0, half_s} : 32'(half_s);
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (acc.size)
      SZ_B: merged[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: RV32I B/H/W accesses onto a word-only memory,
// SB/SH done as read-modify-write. Optional macro MISALIGN_TRAP_EN enables faults.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_LIMIT  = 1024,
  parameter int WORD_ADDR_W = 10
) (
  input logic              CLK,
  input logic              RSTn,
  load_store_unit_if.slave bus
);

  localparam int AW = WORD_ADDR_W + 2;

  state_e         state, state_nxt;
  acc_t           acc_in, acc_p0;
  logic           we_p0;
  logic [AW-1:0]  addr_p0;
  logic [31:0]    wdata_p0;
  logic [31:0]    word_p1;
  logic [31:0]    rdata_p2;
  logic           fault_p0;
  logic           hs, oor, skip, rmw;
  logic [31:0]    word_addr, align_word, load_data, merged;

  assign hs     = bus.REQ_VALID && (state == ST_IDLE);
  assign acc_in = decode_funct3(bus.REQ_FUNCT3, bus.REQ_WE);
  assign oor    = bus.REQ_ADDR >= 32'(ADDR_LIMIT);
  assign rmw    = we_p0 && (acc_p0.size != SZ_W);

`ifdef MISALIGN_TRAP_EN
  logic mis;
  // Out-of-range wins over misalignment: it reports no fault.
  assign mis  = !oor && misaligned(acc_in, bus.REQ_ADDR[1:0]);
  assign skip = oor || mis;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)   fault_p0 <= 1'b0;
    else if (hs) fault_p0 <= mis;
  end
`else
  assign skip     = oor;
  assign fault_p0 = 1'b0;
`endif

  assign word_addr  = {{(32-AW){1'b0}}, addr_p0[AW-1:2], 2'b00};
  assign align_word = (state == ST_WRITE) ? word_p1 : bus.MEM_RD;

  load_store_unit_align u_align (
    .acc       (acc_p0),
    .offset    (addr_p0[1:0]),
    .word      (align_word),
    .wdata     (wdata_p0),
    .load_data (load_data),
    .merged    (merged)
  );

  // Stage p0: request capture on handshake; p1/p2: memory word and response data.
  always_ff @(posedge CLK) begin
    if (hs) begin
      acc_p0   <= acc_in;
      we_p0    <= bus.REQ_WE;
      addr_p0  <= bus.REQ_ADDR[AW-1:0];
      wdata_p0 <= bus.REQ_WDATA;
      rdata_p2 <= '0;
    end
    if (state == ST_ACCESS) begin
      word_p1  <= bus.MEM_RD;
      rdata_p2 <= we_p0 ? '0 : load_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.REQ_VALID) state_nxt = skip ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = rmw ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RESP:   if (bus.RESP_READY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Every output decodes from the async-reset state, so reset drops strobes at once.
  always_comb begin
    bus.REQ_READY  = 1'b0;
    bus.RESP_VALID = 1'b0;
    bus.RESP_RDATA = '0;
    bus.RESP_FAULT = 1'b0;
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b0;
    bus.MEM_ADDR   = '0;
    bus.MEM_WD     = '0;
    case (state)
      ST_IDLE: bus.REQ_READY = 1'b1;
      ST_ACCESS: begin
        bus.MEM_ADDR = word_addr;
        if (we_p0 && !rmw) begin
          bus.MEM_WRITE = 1'b1;
          bus.MEM_WD    = wdata_p0;
        end else begin
          bus.MEM_READ  = 1'b1;
        end
      end
      ST_WRITE: begin
        bus.MEM_ADDR  = word_addr;
        bus.MEM_WRITE = 1'b1;
        bus.MEM_WD    = merged;
      end
      ST_RESP: begin
        bus.RESP_VALID = 1'b1;
        bus.RESP_RDATA = rdata_p2;
        bus.RESP_FAULT = fault_p0;
      end
      default: bus.REQ_READY = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed B/H/W loads, SB/SH RMW,
// out-of-range, response stall, reset mid-RMW and misaligned access.
module tb_load_store_unit;

  logic CLK;
  logic RSTn;

  load_store_unit_if bus ();

  load_store_unit dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          wr_cnt  = 0;
  logic        inv_bad = 1'b0;
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DATA_MEM model: combinational read, write on clock edge.
  assign bus.MEM_RD = bus.MEM_READ ? mem[bus.MEM_ADDR[9:2]] : 32'h0;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (bus.MEM_WRITE) begin
      mem[bus.MEM_ADDR[9:2]] <= bus.MEM_WD;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if ((bus.MEM_READ && bus.MEM_WRITE) || (!bus.MEM_WRITE && bus.MEM_WD != 32'h0))
      inv_bad <= 1'b1;
  end

  // Monitor: pop and compare on every accepted response.
  always @(negedge CLK) begin
    if (bus.RESP_VALID && bus.RESP_READY) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, bus.RESP_RDATA, e.rdata);
        check({e.name, "_fault"}, {31'h0, bus.RESP_FAULT}, {31'h0, e.fault});
      end
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge CLK);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.REQ_READY) check({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
    int lat;
    exp_t e;
    wait_idle(name);
    bus.REQ_WE = we; bus.REQ_FUNCT3 = f3; bus.REQ_ADDR = addr; bus.REQ_WDATA = wdata;
    bus.REQ_VALID = 1'b1;
    e.name = name; e.rdata = exp_rd; e.fault = exp_f;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    lat = 1;
    while (!bus.RESP_VALID && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    RSTn = 1'b0;
    bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_FUNCT3 = 3'b000;
    bus.REQ_ADDR = 32'h0; bus.REQ_WDATA = 32'h0; bus.RESP_READY = 1'b1;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;

    preload(8'd0, 32'h0000_0001);
    preload(8'd1, 32'h0000_0009);
    preload(8'd2, 32'h0000_80F2);
    @(negedge CLK);
    check("rst_req_ready", {31'h0, bus.REQ_READY}, 32'd1);
    check("rst_strobes", {28'h0, bus.RESP_VALID, bus.RESP_FAULT, bus.MEM_READ, bus.MEM_WRITE}, 32'd0);
    check("rst_rdata", bus.RESP_RDATA, 32'h0);
    check("rst_mem_addr", bus.MEM_ADDR, 32'h0);
    check("rst_mem_wd", bus.MEM_WD, 32'h0);
    RSTn = 1'b1;

    issue("lw_4",   1'b0, 3'b010, 32'h4, 32'h0, 32'h0000_0009, 1'b0, 2);
    issue("lb_8",   1'b0, 3'b000, 32'h8, 32'h0, 32'hFFFF_FFF2, 1'b0, 2);
    issue("lbu_8",  1'b0, 3'b100, 32'h8, 32'h0, 32'h0000_00F2, 1'b0, 2);
    issue("lh_8",   1'b0, 3'b001, 32'h8, 32'h0, 32'hFFFF_80F2, 1'b0, 2);
    issue("lb_9",   1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    issue("lhu_a",  1'b0, 3'b101, 32'hA, 32'h0, 32'h0000_0000, 1'b0, 2);
    issue("ill_f3", 1'b0, 3'b011, 32'h8, 32'h0, 32'h0000_80F2, 1'b0, 2);
    issue("lw_oor", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b0, 1);

    w0 = wr_cnt;
    issue("sb_2", 1'b1, 3'b000, 32'h2, 32'h1234_56AB, 32'h0, 1'b0, 3);
    check("sb_write_pulses", 32'(wr_cnt - w0), 32'd1);
    check("sb_mem", mem[0], 32'h00AB_0001);

    w0 = wr_cnt;
    issue("sw_oor", 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    check("sw_oor_no_write", 32'(wr_cnt - w0), 32'd0);
    check("sw_oor_mem", mem[0], 32'h00AB_0001);

    wait_idle("stall");
    bus.RESP_READY = 1'b0;
    issue("stall_lbu", 1'b0, 3'b100, 32'h8, 32'h0, 32'h0000_00F2, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid", {31'h0, bus.RESP_VALID}, 32'd1);
      check("stall_rdata", bus.RESP_RDATA, 32'h0000_00F2);
      check("stall_req_ready", {31'h0, bus.REQ_READY}, 32'd0);
    end
    @(posedge CLK); #1;
    bus.RESP_READY = 1'b1;

    issue("sw_c",   1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    issue("lw_c",   1'b0, 3'b010, 32'hC, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    issue("lh_e",   1'b0, 3'b001, 32'hE, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
    issue("lhu_e",  1'b0, 3'b101, 32'hE, 32'h0, 32'h0000_DEAD, 1'b0, 2);
    issue("sh_e",   1'b1, 3'b001, 32'hE, 32'hABCD_5555, 32'h0, 1'b0, 3);
    issue("lw_c2",  1'b0, 3'b010, 32'hC, 32'h0, 32'h5555_BEEF, 1'b0, 2);
    issue("sbu_10", 1'b1, 3'b100, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 2);
    issue("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2);

    // Reset asserted while an SH sits in WRITE, before its write edge.
    wait_idle("rst_sh");
    bus.REQ_WE = 1'b1; bus.REQ_FUNCT3 = 3'b001; bus.REQ_ADDR = 32'h6;
    bus.REQ_WDATA = 32'h0000_1234; bus.REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    check("rst_sh_in_write", {31'h0, bus.MEM_WRITE}, 32'd1);
    RSTn = 1'b0;
    #1;
    check("rst_sh_strobes", {30'h0, bus.MEM_READ, bus.MEM_WRITE}, 32'd0);
    check("rst_sh_wd", bus.MEM_WD, 32'h0);
    check("rst_sh_req_ready", {31'h0, bus.REQ_READY}, 32'd1);
    @(posedge CLK); #1;
    check("rst_sh_mem", mem[1], 32'h0000_0009);
    @(negedge CLK);
    RSTn = 1'b1;
    issue("lw_4_post", 1'b0, 3'b010, 32'h4, 32'h0, 32'h0000_0009, 1'b0, 2);

`ifdef MISALIGN_TRAP_EN
    issue("lw_5_mis", 1'b0, 3'b010, 32'h5, 32'h0, 32'h0, 1'b1, 1);
`else
    issue("lw_5_mis", 1'b0, 3'b010, 32'h5, 32'h0, 32'h0000_0009, 1'b0, 2);
`endif

    wait_idle("final");
    repeat (2) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("strobe_invariants", {31'h0, inv_bad}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
